// File: rtl/priv_1_11_trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
// Also holds the mstatus rewrite helpers used on trap entry and MRET.
package machine_mode_types_1_11_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLUSH    = 2'd1,
        COMMIT   = 2'd2,
        REDIRECT = 2'd3
    } trap_state_t;

    typedef enum logic [1:0] {
        EXC = 2'd0,
        INT = 2'd1,
        RET = 2'd2
    } trap_kind_t;

    localparam logic [3:0] MEI = 4'd11;
    localparam logic [3:0] MSI = 4'd3;
    localparam logic [3:0] MTI = 4'd7;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    function automatic logic [31:0] trap_entry_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r               = ms;
        r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[12:11]        = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r               = ms;
        r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[12:11]        = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/priv_1_11_trap_sequencer_if.sv
// Pipeline, CSR-file and fetch-side signals of the trap sequencer.
// The sequencer itself connects through the slave modport.
interface priv_1_11_trap_sequencer_if;
    logic        ex_valid;
    logic [3:0]  ex_cause;
    logic [31:0] ex_epc;
    logic [31:0] ex_tval;
    logic        mret;
    logic [31:0] int_epc;
    logic        ext_int;
    logic        timer_int;
    logic        soft_int;
    logic [31:0] mstatus;
    logic [31:0] mie;
    logic [31:0] mtvec;
    logic [31:0] mepc;
    logic        pipe_drained;
    logic        redirect_ack;
    logic        flush_req;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mstatus_rup;
    logic [31:0] mstatus_next;
    logic        mepc_rup;
    logic [31:0] mepc_next;
    logic        mcause_rup;
    logic [31:0] mcause_next;
    logic        mtval_rup;
    logic [31:0] mtval_next;
    logic        mip_rup;
    logic [31:0] mip_next;
    logic        busy;

    modport master (
        output ex_valid, ex_cause, ex_epc, ex_tval, mret, int_epc,
               ext_int, timer_int, soft_int, mstatus, mie, mtvec, mepc,
               pipe_drained, redirect_ack,
        input  flush_req, redirect_valid, redirect_pc,
               mstatus_rup, mstatus_next, mepc_rup, mepc_next,
               mcause_rup, mcause_next, mtval_rup, mtval_next,
               mip_rup, mip_next, busy
    );

    modport slave (
        input  ex_valid, ex_cause, ex_epc, ex_tval, mret, int_epc,
               ext_int, timer_int, soft_int, mstatus, mie, mtvec, mepc,
               pipe_drained, redirect_ack,
        output flush_req, redirect_valid, redirect_pc,
               mstatus_rup, mstatus_next, mepc_rup, mepc_next,
               mcause_rup, mcause_next, mtval_rup, mtval_next,
               mip_rup, mip_next, busy
    );
endinterface

// File: rtl/priv_1_11_int_sync.sv
// Multi-flop synchronizer for asynchronous interrupt lines.
// STAGES must be at least 2 for metastability settling.
module priv_1_11_int_sync #(
    parameter int WIDTH  = 3,
    parameter int STAGES = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/priv_1_11_trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: arbitrate, drain, commit CSRs, redirect fetch.
// state    | meaning
// IDLE     | accepting exception / interrupt / mret requests
// FLUSH    | holding flush_req until the pipeline reports drained
// COMMIT   | single cycle, atomic CSR write strobes
// REDIRECT | presenting redirect_pc until fetch acknowledges
module priv_1_11_trap_sequencer
    import machine_mode_types_1_11_pkg::*;
#(
    parameter bit VECTORED_EN = 1'b1,
    parameter int SYNC_STAGES = 2
) (
    input logic                          CLK,
    input logic                          nRST,
    priv_1_11_trap_sequencer_if.slave    bus
);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_FLUSH    = FLUSH;
    localparam logic [1:0] S_COMMIT   = COMMIT;
    localparam logic [1:0] S_REDIRECT = REDIRECT;

    localparam logic [1:0] K_EXC = EXC;
    localparam logic [1:0] K_INT = INT;
    localparam logic [1:0] K_RET = RET;

    logic [1:0]  state_q, state_d;
    logic [1:0]  kind_q, kind_d;
    logic [3:0]  cause_q, cause_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] tval_q, tval_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        mip_rup_q;

    logic [2:0]  int_raw, int_sync;
    logic [31:0] mip_w, int_enabled;
    logic        int_pend;
    logic [3:0]  int_cause;
    logic [31:0] trap_base, trap_target;
    logic        commit, is_ret;

    // bit order {ext, timer, soft}
    assign int_raw = {bus.ext_int, bus.timer_int, bus.soft_int};

    priv_1_11_int_sync #(
        .WIDTH  (3),
        .STAGES (SYNC_STAGES)
    ) u_int_sync (
        .CLK  (CLK),
        .nRST (nRST),
        .d_i  (int_raw),
        .q_o  (int_sync)
    );

    always_comb begin
        mip_w     = 32'b0;
        mip_w[11] = int_sync[2];
        mip_w[7]  = int_sync[1];
        mip_w[3]  = int_sync[0];
    end

    assign int_enabled = mip_w & bus.mie;
    assign int_pend    = bus.mstatus[MSTATUS_MIE] & (|int_enabled);
    assign int_cause   = int_enabled[11] ? MEI : (int_enabled[3] ? MSI : MTI);

    // Vector offset is a plain 32-bit add so a high base wraps rather than saturates.
    assign trap_base = {bus.mtvec[31:2], 2'b00};
    always_comb begin
        trap_target = trap_base;
        if (VECTORED_EN && kind_q == K_INT && bus.mtvec[1:0] == 2'b01) begin
            trap_target = trap_base + {26'b0, cause_q, 2'b00};
        end
    end

    always_comb begin
        state_d       = state_q;
        kind_d        = kind_q;
        cause_d       = cause_q;
        epc_d         = epc_q;
        tval_d        = tval_q;
        redirect_pc_d = redirect_pc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.ex_valid) begin
                    kind_d  = K_EXC;
                    cause_d = bus.ex_cause;
                    epc_d   = bus.ex_epc;
                    tval_d  = bus.ex_tval;
                    state_d = S_FLUSH;
                end else if (int_pend) begin
                    kind_d  = K_INT;
                    cause_d = int_cause;
                    epc_d   = bus.int_epc;
                    tval_d  = 32'b0;
                    state_d = S_FLUSH;
                end else if (bus.mret) begin
                    kind_d  = K_RET;
                    cause_d = 4'b0;
                    epc_d   = 32'b0;
                    tval_d  = 32'b0;
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (bus.pipe_drained) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                // mepc is sampled before the CSR file sees any MRET write, so it is the return PC.
                redirect_pc_d = (kind_q == K_RET) ? bus.mepc : trap_target;
                state_d       = S_REDIRECT;
            end
            S_REDIRECT: begin
                if (bus.redirect_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q       <= S_IDLE;
            kind_q        <= K_EXC;
            cause_q       <= 4'b0;
            epc_q         <= 32'b0;
            tval_q        <= 32'b0;
            redirect_pc_q <= 32'b0;
            mip_rup_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            cause_q       <= cause_d;
            epc_q         <= epc_d;
            tval_q        <= tval_d;
            redirect_pc_q <= redirect_pc_d;
            mip_rup_q     <= 1'b1;
        end
    end

    assign commit = (state_q == S_COMMIT);
    assign is_ret = (kind_q == K_RET);

    assign bus.busy           = (state_q != S_IDLE);
    assign bus.flush_req      = (state_q != S_IDLE);
    assign bus.redirect_valid = (state_q == S_REDIRECT);
    assign bus.redirect_pc    = (state_q == S_REDIRECT) ? redirect_pc_q : 32'b0;

    assign bus.mstatus_rup  = commit;
    assign bus.mstatus_next = !commit ? 32'b0 :
                              (is_ret ? mret_mstatus(bus.mstatus) : trap_entry_mstatus(bus.mstatus));
    assign bus.mepc_rup     = commit & ~is_ret;
    assign bus.mepc_next    = bus.mepc_rup ? {epc_q[31:2], 2'b00} : 32'b0;
    assign bus.mcause_rup   = commit & ~is_ret;
    assign bus.mcause_next  = bus.mcause_rup ? {(kind_q == K_INT), 27'b0, cause_q} : 32'b0;
    assign bus.mtval_rup    = commit & ~is_ret;
    assign bus.mtval_next   = (bus.mtval_rup && kind_q == K_EXC) ? tval_q : 32'b0;

    assign bus.mip_rup  = mip_rup_q;
    assign bus.mip_next = mip_w;

endmodule

// File: tb/tb_priv_1_11_trap_sequencer.sv
// Randomized scoreboard bench for the trap sequencer; the bench itself plays the CSR file,
// pipeline and fetch unit, and predicts each commit/redirect from the architectural trap rules.
module tb_priv_1_11_trap_sequencer;
    import machine_mode_types_1_11_pkg::*;

    localparam int SYNC = 2;
    localparam bit VEC  = 1'b1;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    priv_1_11_trap_sequencer_if bus ();

    priv_1_11_trap_sequencer #(
        .VECTORED_EN (VEC),
        .SYNC_STAGES (SYNC)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus.slave)
    );

    logic [31:0] csr_ms, csr_mie, csr_mtvec, csr_mepc;
    assign bus.mstatus = csr_ms;
    assign bus.mie     = csr_mie;
    assign bus.mtvec   = csr_mtvec;
    assign bus.mepc    = csr_mepc;

    typedef struct packed {
        logic        is_ret;
        logic [31:0] ms;
        logic [31:0] mepc;
        logic [31:0] mcause;
        logic [31:0] mtval;
    } commit_t;

    commit_t     cq[$];
    logic [31:0] rq[$];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural reference: who wins, what the CSR file receives, where fetch goes.
    task automatic predict(input logic exv, input logic mr, input logic [2:0] lines,
                           input logic [3:0] cause, input logic [31:0] epc,
                           input logic [31:0] tval, input logic [31:0] ie,
                           output commit_t c, output logic [31:0] pc);
        bit meip_on, msip_on, mtip_on, take_int;
        int code;
        meip_on  = lines[2] && csr_mie[11];
        mtip_on  = lines[1] && csr_mie[7];
        msip_on  = lines[0] && csr_mie[3];
        take_int = csr_ms[3] && (meip_on || mtip_on || msip_on);
        c = '0;
        if (exv || take_int) begin
            code = exv ? int'(cause) : (meip_on ? 11 : (msip_on ? 3 : 7));
            c.ms         = csr_ms;
            c.ms[7]      = csr_ms[3];
            c.ms[3]      = 1'b0;
            c.ms[12:11]  = 2'b11;
            c.mepc       = (exv ? epc : ie) & 32'hFFFF_FFFC;
            c.mcause     = (exv ? 32'h0 : 32'h8000_0000) + 32'(code);
            c.mtval      = exv ? tval : 32'h0;
            pc = csr_mtvec & 32'hFFFF_FFFC;
            if (!exv && VEC && csr_mtvec[1:0] == 2'b01) pc = pc + 32'(code * 4);
        end else begin
            c.is_ret     = 1'b1;
            c.ms         = csr_ms;
            c.ms[3]      = csr_ms[7];
            c.ms[7]      = 1'b1;
            c.ms[12:11]  = 2'b11;
            pc = csr_mepc;
        end
        if (!exv && !take_int && !mr) $display("bench note: no request predicted");
    endtask

    // Monitor: scoreboard pops, mip path, redirect stability, reset quiescence.
    logic [2:0]  hist [SYNC];
    logic        prev_rv = 1'b0;
    logic [31:0] prev_pc = 32'h0;
    always @(posedge CLK) begin
        logic any_out;
        logic [2:0] h;
        logic [31:0] exp_mip;
        commit_t e;
        if (!nRST) begin
            for (int i = 0; i < SYNC; i++) hist[i] = 3'b0;
        end else begin
            for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = {bus.ext_int, bus.timer_int, bus.soft_int};
        end
        #1;
        if (!nRST) begin
            any_out = bus.flush_req | bus.redirect_valid | (|bus.redirect_pc) |
                      bus.mstatus_rup | (|bus.mstatus_next) | bus.mepc_rup | (|bus.mepc_next) |
                      bus.mcause_rup | (|bus.mcause_next) | bus.mtval_rup | (|bus.mtval_next) |
                      bus.mip_rup | (|bus.mip_next) | bus.busy;
            check("reset_outputs_zero", {31'b0, any_out}, 32'h0);
            prev_rv = 1'b0;
        end else begin
            h = hist[SYNC-1];
            exp_mip = 32'h0;
            exp_mip[11] = h[2];
            exp_mip[7]  = h[1];
            exp_mip[3]  = h[0];
            check("mip_rup", {31'b0, bus.mip_rup}, 32'h1);
            check("mip_next", bus.mip_next, exp_mip);
            if (bus.mstatus_rup | bus.mepc_rup | bus.mcause_rup | bus.mtval_rup) begin
                if (cq.size() == 0) begin
                    check("unexpected_commit", 32'h1, 32'h0);
                end else begin
                    e = cq.pop_front();
                    check("rup_pattern", {28'b0, bus.mstatus_rup, bus.mepc_rup, bus.mcause_rup, bus.mtval_rup},
                          e.is_ret ? 32'h8 : 32'hF);
                    check("mstatus_next", bus.mstatus_next, e.ms);
                    if (!e.is_ret) begin
                        check("mepc_next", bus.mepc_next, e.mepc);
                        check("mcause_next", bus.mcause_next, e.mcause);
                        check("mtval_next", bus.mtval_next, e.mtval);
                    end
                end
            end
            if (bus.redirect_valid) begin
                if (!prev_rv) begin
                    if (rq.size() == 0) check("unexpected_redirect", 32'h1, 32'h0);
                    else check("redirect_pc", bus.redirect_pc, rq.pop_front());
                end else begin
                    check("redirect_pc_stable", bus.redirect_pc, prev_pc);
                end
                check("flush_in_redirect", {31'b0, bus.flush_req}, 32'h1);
            end
            prev_rv = bus.redirect_valid;
            prev_pc = bus.redirect_pc;
        end
    end

    task automatic wait_flush(output int n);
        n = 0;
        do begin
            @(posedge CLK); #1;
            n++;
        end while (!bus.flush_req && n < 30);
        if (!bus.flush_req) check("flush_timeout", 32'h0, 32'h1);
    endtask

    task automatic run_txn(input logic exv, input logic mr, input logic [2:0] lines,
                           input logic [3:0] cause, input logic [31:0] epc, input logic [31:0] tval,
                           input logic [31:0] ie, input int drain, input int ackd, input logic poke);
        commit_t c;
        logic [31:0] pc;
        int n;
        predict(exv, mr, lines, cause, epc, tval, ie, c, pc);
        cq.push_back(c);
        rq.push_back(pc);
        @(negedge CLK);
        bus.ex_valid  = exv;
        bus.ex_cause  = cause;
        bus.ex_epc    = epc;
        bus.ex_tval   = tval;
        bus.mret      = mr;
        bus.int_epc   = ie;
        bus.ext_int   = lines[2];
        bus.timer_int = lines[1];
        bus.soft_int  = lines[0];
        wait_flush(n);
        if (exv || mr) check("flush_latency", 32'(n), 32'h1);
        @(negedge CLK);
        bus.ex_valid = 1'b0;
        bus.mret     = 1'b0;
        repeat (drain) @(negedge CLK);
        bus.pipe_drained = 1'b1;
        @(posedge CLK); #1;
        check("commit_latency", {31'b0, bus.mstatus_rup}, 32'h1);
        @(posedge CLK); #1;
        check("redirect_latency", {31'b0, bus.redirect_valid}, 32'h1);
        @(negedge CLK);
        bus.pipe_drained = 1'b0;
        if (poke) begin
            bus.ex_valid = 1'b1;
            bus.ex_cause = 4'($urandom_range(0, 15));
        end
        repeat (ackd) @(negedge CLK);
        bus.ex_valid     = 1'b0;
        bus.redirect_ack = 1'b1;
        @(posedge CLK); #1;
        check("idle_after_ack", {31'b0, bus.busy}, 32'h0);
        @(negedge CLK);
        bus.redirect_ack = 1'b0;
        csr_ms = c.ms;
        if (!c.is_ret) csr_mepc = c.mepc;
    endtask

    task automatic clear_lines();
        @(negedge CLK);
        bus.ext_int   = 1'b0;
        bus.timer_int = 1'b0;
        bus.soft_int  = 1'b0;
        repeat (SYNC + 3) @(negedge CLK);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, kind, j;
        logic [31:0] ie;
        bus.ex_valid = 0; bus.ex_cause = 0; bus.ex_epc = 0; bus.ex_tval = 0;
        bus.mret = 0; bus.int_epc = 0; bus.ext_int = 0; bus.timer_int = 0; bus.soft_int = 0;
        bus.pipe_drained = 0; bus.redirect_ack = 0;
        csr_ms = 0; csr_mie = 0; csr_mtvec = 0; csr_mepc = 0;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        repeat (3) @(negedge CLK);

        // exception into direct handler
        csr_ms = 32'h8; csr_mtvec = 32'h200;
        run_txn(1, 0, 3'b000, 4'd2, 32'h104, 32'hDEAD, 32'h0, 3, 0, 0);

        // vectored timer interrupt
        csr_ms = 32'h8; csr_mie = 32'h80; csr_mtvec = 32'h301;
        run_txn(0, 0, 3'b010, 4'd0, 32'h0, 32'h0, 32'h40, 1, 0, 0);
        clear_lines();

        // simultaneous requests, then mret-driven interrupt priority
        csr_ms = 32'h8; csr_mie = 32'h888; csr_mtvec = 32'h1001;
        ie = 32'h5000;
        run_txn(1, 0, 3'b101, 4'd5, 32'h900, 32'h77, ie, 1, 0, 0);
        run_txn(0, 1, 3'b101, 4'd0, 32'h0, 32'h0, ie, 1, 1, 0);
        run_txn(0, 0, 3'b101, 4'd0, 32'h0, 32'h0, ie, 1, 1, 0);
        run_txn(0, 1, 3'b101, 4'd0, 32'h0, 32'h0, ie, 1, 1, 0);
        run_txn(0, 0, 3'b101, 4'd0, 32'h0, 32'h0, ie, 1, 1, 0);
        clear_lines();

        // mret back to saved mepc
        csr_ms = 32'h80; csr_mepc = 32'h88;
        run_txn(0, 1, 3'b000, 4'd0, 32'h0, 32'h0, 32'h0, 0, 0, 0);

        // reset asserted mid-FLUSH drops the trap
        csr_ms = 32'h8;
        @(negedge CLK);
        bus.ex_valid = 1; bus.ex_cause = 4'd4; bus.ex_epc = 32'h300; bus.ex_tval = 32'h1;
        wait_flush(n);
        check("flush_before_reset", 32'(n), 32'h1);
        @(negedge CLK);
        nRST = 1'b0;
        bus.ex_valid = 0;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        bus.pipe_drained = 1'b1;
        repeat (5) @(negedge CLK);
        bus.pipe_drained = 1'b0;
        check("busy_after_reset", {31'b0, bus.busy}, 32'h0);

        // slow ack with a new exception arriving during REDIRECT
        csr_ms = 32'h8; csr_mtvec = 32'h400;
        run_txn(1, 0, 3'b000, 4'd7, 32'h222, 32'h33, 32'h0, 0, 5, 1);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 2);
            csr_ms    = $urandom;
            csr_mtvec = $urandom;
            csr_mepc  = $urandom;
            csr_mie   = $urandom;
            if (kind == 0) begin
                run_txn(1, 0, 3'b000, 4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
                        $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end else if (kind == 1) begin
                n = $urandom_range(1, 7);
                j = (n[2] ? 2 : (n[1] ? 1 : 0));
                csr_ms[3] = 1'b1;
                csr_mie[(j == 2) ? 11 : ((j == 1) ? 7 : 3)] = 1'b1;
                if ($urandom_range(0, 1) == 1) csr_mtvec[1:0] = 2'b01;
                run_txn(0, 0, 3'(n), 4'd0, 32'h0, 32'h0, $urandom,
                        $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                clear_lines();
            end else begin
                run_txn(0, 1, 3'b000, 4'd0, 32'h0, 32'h0, 32'h0,
                        $urandom_range(0, 4), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            end
        end

        repeat (5) @(negedge CLK);
        check("commit_queue_empty", 32'(cq.size()), 32'h0);
        check("redirect_queue_empty", 32'(rq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
